btn_bank_debounce: RTL

Parametrised N-channel button front end: per channel it synchronises an asynchronous raw input, debounces it, and emits a clean level, press/release pulses, and a long-press pulse. It can optionally emit a periodic auto-repeat pulse while a button stays held. It sits between the board push-buttons and the counter/OLED control logic, and it replaces the single-channel debouncers with one bank.

---
 rtl/btn_bank_debounce.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/btn_bank_debounce.sv
// Purpose: N-channel push-button front end: 2-flop sync, debounce, press/release/long-press pulses.
// Latency: level/rise/fall 2+DB_CYC cycles after a stable raw edge; long_press LONG_CYC cycles after rise.
// Backpressure: none; every output is a registered level or a 1-cycle pulse, so the consumer samples each cycle.
// Build option: define BTN_REPEAT_EN to add the LONG state and periodic repeat_p; otherwise repeat_p is 0.
module btn_bank_debounce #(
    parameter int N_BTN       = 4,
    parameter int CLK_HZ      = 50_000_000,
    parameter int DEBOUNCE_MS = 5,
    parameter int LONG_MS     = 1000,
    parameter int REPEAT_MS   = 200,
    parameter bit ACTIVE_LOW  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] level,
    output logic [N_BTN-1:0] rise,
    output logic [N_BTN-1:0] fall,
    output logic [N_BTN-1:0] long_press,
    output logic [N_BTN-1:0] repeat_p
);

    localparam int DB_CYC   = (CLK_HZ / 1000) * DEBOUNCE_MS;
    localparam int LONG_CYC = (CLK_HZ / 1000) * LONG_MS;
    localparam int REP_CYC  = (CLK_HZ / 1000) * REPEAT_MS;

    // One hold counter per channel serves both the long-press and the repeat interval.
    localparam int DB_W = $clog2(DB_CYC + 1);
    localparam int HC_W = $clog2(((LONG_CYC > REP_CYC) ? LONG_CYC : REP_CYC) + 1);

    localparam logic [DB_W-1:0] DB_TERM = DB_W'(DB_CYC - 1);
    localparam logic [HC_W-1:0] LG_TERM = HC_W'(LONG_CYC - 1);
    // Parking value once long_press has fired and no repeat logic exists.
    localparam logic [HC_W-1:0] LG_DONE = HC_W'(LONG_CYC);
`ifdef BTN_REPEAT_EN
    localparam logic [HC_W-1:0] RP_TERM = HC_W'(REP_CYC - 1);
`endif

    if (DB_CYC < 2) begin : g_chk_db
        $error("btn_bank_debounce: DB_CYC must be at least 2");
    end
    if (LONG_CYC <= DB_CYC) begin : g_chk_long
        $error("btn_bank_debounce: LONG_CYC must exceed DB_CYC");
    end
    if (REP_CYC < 1) begin : g_chk_rep
        $error("btn_bank_debounce: REP_CYC must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HELD = 2'd1,
        S_LONG = 2'd2
    } hold_state_t;

    // Polarity is corrected ahead of the first flop so everything downstream sees 1 = pressed.
    logic [N_BTN-1:0] pol_raw;
    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync2_q;

    assign pol_raw = ACTIVE_LOW ? ~btn_raw : btn_raw;

    // Two-flop synchroniser for the asynchronous button inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= pol_raw;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic [DB_W-1:0] db_cnt_q;
        logic [DB_W-1:0] db_cnt_d;
        logic            commit;
        logic            press_commit;
        logic            release_commit;
        logic            level_q;
        logic            rise_q;
        logic            fall_q;
        logic            long_q;
        logic [HC_W-1:0] hold_cnt_q;
        hold_state_t     state_q;
`ifdef BTN_REPEAT_EN
        logic            rep_q;
`endif

        // Debounce: count while the synced value disagrees with level; any agreement restarts.
        always_comb begin
            commit   = 1'b0;
            db_cnt_d = '0;
            if (sync2_q[i] != level_q) begin
                if (db_cnt_q == DB_TERM) begin
                    commit = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
        end

        assign press_commit   = commit & sync2_q[i];
        assign release_commit = commit & ~sync2_q[i];

        // Committed level and its edge pulses change together on the commit cycle.
        always_ff @(posedge clk) begin
            if (rst) begin
                db_cnt_q <= '0;
                level_q  <= 1'b0;
                rise_q   <= 1'b0;
                fall_q   <= 1'b0;
            end else begin
                db_cnt_q <= db_cnt_d;
                if (commit) begin
                    level_q <= sync2_q[i];
                end
                rise_q <= press_commit;
                fall_q <= release_commit;
            end
        end

        // Hold FSM: time the press, pulse long_press (and repeat_p); a release commit always wins.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q    <= S_IDLE;
                hold_cnt_q <= '0;
                long_q     <= 1'b0;
`ifdef BTN_REPEAT_EN
                rep_q      <= 1'b0;
`endif
            end else begin
                long_q <= 1'b0;
`ifdef BTN_REPEAT_EN
                rep_q  <= 1'b0;
`endif
                if (release_commit) begin
                    state_q    <= S_IDLE;
                    hold_cnt_q <= '0;
                end else begin
                    case (state_q)
                        S_IDLE: begin
                            if (press_commit) begin
                                state_q    <= S_HELD;
                                hold_cnt_q <= '0;
                            end
                        end
                        S_HELD: begin
                            if (hold_cnt_q == LG_TERM && level_q) begin
                                long_q <= 1'b1;
`ifdef BTN_REPEAT_EN
                                state_q    <= S_LONG;
                                hold_cnt_q <= '0;
`else
                                hold_cnt_q <= LG_DONE;
`endif
                            end else if (hold_cnt_q != LG_DONE) begin
                                hold_cnt_q <= hold_cnt_q + 1'b1;
                            end
                        end
`ifdef BTN_REPEAT_EN
                        S_LONG: begin
                            if (hold_cnt_q == RP_TERM) begin
                                rep_q      <= 1'b1;
                                hold_cnt_q <= '0;
                            end else begin
                                hold_cnt_q <= hold_cnt_q + 1'b1;
                            end
                        end
`endif
                        default: begin
                            state_q    <= S_IDLE;
                            hold_cnt_q <= '0;
                        end
                    endcase
                end
            end
        end

        assign level[i]      = level_q;
        assign rise[i]       = rise_q;
        assign fall[i]       = fall_q;
        assign long_press[i] = long_q;
`ifdef BTN_REPEAT_EN
        assign repeat_p[i]   = rep_q;
`else
        assign repeat_p[i]   = 1'b0;
`endif
    end

endmodule
